piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter that takes N-bit words over a valid/ready handshake and emits them one bit per cycle, LSB first. It sits directly upstream of the right-shifting serial capture register. That register inserts at the MSB and shifts on each `bit_valid` cycle, so after N shifts it holds the original word unchanged. A one-entry holding buffer lets the block accept the next word while the current one is shifting, which gives gapless back-to-back streams.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_serializer_if.sv | 26 ++
 rtl/piso_hold_buf.sv | 32 +++
 rtl/piso_serializer.sv | 138 +++++++++++++
 tb/tb_piso_serializer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } piso_state_t;

    // Width of the bit counter; it must be able to represent 0..N.
    function automatic int piso_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake and serial output bundle of the PISO serializer.
interface piso_serializer_if #(
    parameter int N = 8
);

    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         serial_out;
    logic         bit_valid;
    logic         last_bit;
    logic         busy;

    // master: upstream word source that also observes the serial side.
    modport master (
        output in_data, in_valid,
        input  in_ready, serial_out, bit_valid, last_bit, busy
    );

    // slave: the serializer itself.
    modport slave (
        input  in_data, in_valid,
        output in_ready, serial_out, bit_valid, last_bit, busy
    );

endinterface

// File: rtl/piso_hold_buf.sv
// One-entry holding register that parks the next word while the current one shifts.
module piso_hold_buf #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [N-1:0] wr_data,
    output logic [N-1:0] data,
    output logic         hvalid
);

    // NOTE: the data register is deliberately not reset; hvalid alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data <= wr_data;
        end
    end

    // Writes only happen while empty and reads only while full, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hvalid <= 1'b0;
        end else if (wr_en) begin
            hvalid <= 1'b1;
        end else if (rd_en) begin
            hvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, LSB first, gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);

    localparam int             CW       = piso_cnt_w(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    piso_state_t   state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic          par_q, par_d;
`endif

    logic [N-1:0]  hb_data;
    logic          hvalid;
    logic          hb_wr;
    logic          hb_rd;
    logic          accept;
    logic          eof;
    logic          load;
    logic [N-1:0]  load_word;

    assign accept = bus.in_valid && bus.in_ready;

    piso_hold_buf #(.N(N)) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hb_wr),
        .rd_en   (hb_rd),
        .wr_data (bus.in_data),
        .data    (hb_data),
        .hvalid  (hvalid)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        hb_wr     = 1'b0;
        hb_rd     = 1'b0;
        eof       = 1'b0;
        load      = 1'b0;
        load_word = bus.in_data;

        case (state_q)
            IDLE: begin
                load = accept;
            end
            SHIFT: begin
                sreg_d = {1'b0, sreg_q[N-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
                    hb_wr   = accept;
`else
                    eof     = 1'b1;
`endif
                end else begin
                    hb_wr = accept;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                eof = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of frame: the held word wins, then a word arriving now, else go idle.
        if (eof) begin
            if (hvalid) begin
                load      = 1'b1;
                load_word = hb_data;
                hb_rd     = 1'b1;
            end else if (accept) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (load) begin
            sreg_d  = load_word;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

`ifdef PISO_PARITY_EN
    assign par_d = load ? ^load_word : par_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.in_ready  = !hvalid && !rst;
    assign bus.bit_valid = (state_q != IDLE);
    assign bus.busy      = (state_q != IDLE) || hvalid;

`ifdef PISO_PARITY_EN
    assign bus.serial_out = ((state_q == SHIFT) && sreg_q[0]) || ((state_q == PARITY) && par_q);
    assign bus.last_bit   = (state_q == PARITY);
`else
    assign bus.serial_out = (state_q == SHIFT) && sreg_q[0];
    assign bus.last_bit   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: queue-based frame model plus directed literal checks.
module tb_piso_serializer;

    localparam int N = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_serializer_if #(.N(N)) bus ();

    piso_serializer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: bits still to be sent for the current frame, plus the one parked word.
    bit           frame[$];
    logic [N-1:0] m_held;
    bit           m_held_v = 1'b0;

    // Observed serial stream, for the directed literal checks.
    bit           got_bits[$];
    bit           got_last[$];
    int           got_cyc[$];
    int           cyc     = 0;
    int           rdy_low = 0;
    logic [N-1:0] cap     = '0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) frame.push_back(w[i]);
`ifdef PISO_PARITY_EN
        frame.push_back(^w);
`endif
    endtask

    // Compare process: outputs are stable at the falling edge; then advance the model past the next rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_ready, exp_bv, exp_so, exp_last, exp_busy, acc, taken;
            exp_ready = !m_held_v && !rst;
            exp_bv    = (frame.size() != 0);
            exp_so    = exp_bv ? frame[0] : 1'b0;
            exp_last  = exp_bv && (frame.size() == 1);
            exp_busy  = exp_bv || m_held_v;
            check("in_ready",   bus.in_ready,   exp_ready);
            check("bit_valid",  bus.bit_valid,  exp_bv);
            check("serial_out", bus.serial_out, exp_so);
            check("last_bit",   bus.last_bit,   exp_last);
            check("busy",       bus.busy,       exp_busy);

            cyc++;
            if (!bus.in_ready && !rst) rdy_low++;
            if (bus.bit_valid) begin
                got_bits.push_back(bus.serial_out);
                got_last.push_back(bus.last_bit);
                got_cyc.push_back(cyc);
                cap = {bus.serial_out, cap[N-1:1]};
            end

            if (rst) begin
                frame.delete();
                m_held_v = 1'b0;
            end else begin
                acc   = bus.in_valid && exp_ready;
                taken = 1'b0;
                if (frame.size() != 0) void'(frame.pop_front());
                if (frame.size() == 0) begin
                    if (m_held_v) begin
                        push_frame(m_held);
                        m_held_v = 1'b0;
                    end else if (acc) begin
                        push_frame(bus.in_data);
                        taken = 1'b1;
                    end
                end
                if (acc && !taken) begin
                    m_held   = bus.in_data;
                    m_held_v = 1'b1;
                end
            end
        end
    end

    // Presents a word and returns just after the edge that accepts it, leaving in_valid high.
    task automatic send_word(input logic [N-1:0] w);
        bit acc;
        acc          = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check("send_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        check("idle_reached", idle, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_bits.delete();
        got_last.delete();
        got_cyc.delete();
        rdy_low = 0;
    endtask

    task automatic check_stream(input string nm, input logic [31:0] exp_v, input int exp_len, input int exp_frames);
        logic [31:0] v;
        int          lasts;
        v     = '0;
        lasts = 0;
        check({nm, "_len"}, got_bits.size(), exp_len);
        for (int i = 0; i < got_bits.size() && i < 32; i++) begin
            v[i]  = got_bits[i];
            lasts = lasts + int'(got_last[i]);
        end
        check({nm, "_bits"}, v, exp_v);
        check({nm, "_last_count"}, lasts, exp_frames);
        if (got_bits.size() > 0) begin
            check({nm, "_final_last"}, got_last[got_bits.size()-1], 1);
            check({nm, "_gapless"}, got_cyc[got_bits.size()-1] - got_cyc[0], got_bits.size() - 1);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_serial_out", bus.serial_out, 0);
        check("rst_bit_valid",  bus.bit_valid,  0);
        check("rst_last_bit",   bus.last_bit,   0);
        check("rst_busy",       bus.busy,       0);
        check("rst_in_ready",   bus.in_ready,   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Single frame.
        clear_log();
        send_word(8'hA5);
        bus.in_valid = 1'b0;
        wait_idle();
`ifdef PISO_PARITY_EN
        check_stream("single_a5", 32'h0A5, 9, 1);
`else
        check_stream("single_a5", 32'hA5, 8, 1);
`endif

        // Back-to-back pair, then a third word stalled behind the full holding buffer.
        clear_log();
        send_word(8'h01);
        send_word(8'h80);
        send_word(8'h3C);
        bus.in_valid = 1'b0;
        wait_idle();
`ifdef PISO_PARITY_EN
        check_stream("b2b_stall", {5'd0, 9'h03C, 9'h180, 9'h101}, 27, 3);
`else
        check_stream("b2b_stall", 32'h3C8001, 24, 3);
`endif
        check("b2b_ready_low_cycles", rdy_low, 2 * (FL - 1));

`ifdef PISO_PARITY_EN
        clear_log();
        send_word(8'h07);
        bus.in_valid = 1'b0;
        wait_idle();
        check_stream("parity_07", 32'h107, 9, 1);
        clear_log();
        send_word(8'h03);
        bus.in_valid = 1'b0;
        wait_idle();
        check_stream("parity_03", 32'h003, 9, 1);
`endif

        // Reset in the middle of a frame with a word held.
        send_word(8'h5A);
        send_word(8'h99);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_serial_out", bus.serial_out, 0);
        check("midrst_bit_valid",  bus.bit_valid,  0);
        check("midrst_last_bit",   bus.last_bit,   0);
        check("midrst_busy",       bus.busy,       0);
        check("midrst_in_ready",   bus.in_ready,   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        send_word(8'hFF);
        bus.in_valid = 1'b0;
        wait_idle();
`ifdef PISO_PARITY_EN
        check_stream("after_rst_ff", 32'h0FF, 9, 1);
`else
        check_stream("after_rst_ff", 32'hFF, 8, 1);
`endif

        // Downstream capture register shifting on bit_valid.
        send_word(8'hC3);
        bus.in_valid = 1'b0;
        wait_idle();
`ifdef PISO_PARITY_EN
        check("capture_c3", cap, 8'h61);
`else
        check("capture_c3", cap, 8'hC3);
`endif

        // Randomised traffic with occasional resets; the compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            bit acc;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = N'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
